// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: per-word write mode encodings.
package register_bank_pkg;

  localparam logic [1:0] WR_HOLD = 2'b00;
  localparam logic [1:0] WR_LOAD = 2'b01;
  localparam logic [1:0] WR_INC  = 2'b10;
  localparam logic [1:0] WR_DEC  = 2'b11;

endpackage

// File: rtl/register_bank_cell.sv
// One word of the register bank: next-value mux, async reset/preset, edge select
// and combinational wrap detect for the current update.
module register_bank_cell
  import register_bank_pkg::*;
#(
  parameter bit          ActiveLevel = 1'b1,
  parameter int unsigned NrOfBits    = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  logic                sel,
  input  logic [1:0]          mode,
  input  logic [NrOfBits-1:0] d,
  output logic [NrOfBits-1:0] word,
  output logic                wrap
);

  logic [NrOfBits-1:0] word_d;

  always_comb begin
    word_d = word;
    if (sel) begin
      unique case (mode)
        WR_LOAD: word_d = d;
        WR_INC:  word_d = word + NrOfBits'(1);
        WR_DEC:  word_d = word - NrOfBits'(1);
        default: word_d = word;
      endcase
    end
  end

  assign wrap = sel && (((mode == WR_INC) && (word == '1)) ||
                        ((mode == WR_DEC) && (word == '0)));

  // Only one of these processes is elaborated, chosen by the active edge.
  if (ActiveLevel) begin : g_rise
    always_ff @(posedge Clock or posedge Reset or posedge pre) begin
      if (Reset)    word <= '0;
      else if (pre) word <= '1;
      else          word <= word_d;
    end
  end else begin : g_fall
    always_ff @(negedge Clock or posedge Reset or posedge pre) begin
      if (Reset)    word <= '0;
      else if (pre) word <= '1;
      else          word <= word_d;
    end
  end

endmodule

// File: rtl/register_bank_s10.sv
// Register bank with load/increment/decrement per word, registered wrap pulse
// and two combinational tri-state read ports.
module register_bank_s10 #(
  parameter bit          ActiveLevel = 1'b1,
  parameter int unsigned NrOfBits    = 8,
  parameter int unsigned NrOfRegs    = 4,
  parameter int unsigned AddrBits    = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [1:0]          WrMode,
  input  logic [NrOfBits-1:0] D,
  input  logic [AddrBits-1:0] RdAddrA,
  input  logic [AddrBits-1:0] RdAddrB,
  input  logic                csA,
  input  logic                csB,
  output logic [NrOfBits-1:0] QA,
  output logic [NrOfBits-1:0] QB,
  output logic                Wrap
);

  logic [NrOfBits-1:0] words [NrOfRegs];
  logic [NrOfRegs-1:0] cell_wrap;
  logic                qual;
  logic                wrap_d;
  logic [NrOfBits-1:0] rd_a;
  logic [NrOfBits-1:0] rd_b;

  assign qual = ClockEnable & Tick;

  for (genvar i = 0; i < NrOfRegs; i++) begin : g_cell
    register_bank_cell #(
      .ActiveLevel (ActiveLevel),
      .NrOfBits    (NrOfBits)
    ) u_cell (
      .Clock (Clock),
      .Reset (Reset),
      .pre   (pre),
      .sel   (qual && (WrAddr == AddrBits'(i))),
      .mode  (WrMode),
      .d     (D),
      .word  (words[i]),
      .wrap  (cell_wrap[i])
    );
  end

  assign wrap_d = |cell_wrap;

  if (ActiveLevel) begin : g_wrap_rise
    always_ff @(posedge Clock or posedge Reset or posedge pre) begin
      if (Reset)    Wrap <= 1'b0;
      else if (pre) Wrap <= 1'b0;
      else          Wrap <= wrap_d;
    end
  end else begin : g_wrap_fall
    always_ff @(negedge Clock or posedge Reset or posedge pre) begin
      if (Reset)    Wrap <= 1'b0;
      else if (pre) Wrap <= 1'b0;
      else          Wrap <= wrap_d;
    end
  end

  // Addresses beyond the last word match nothing and read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (RdAddrA == AddrBits'(i)) rd_a = words[i];
      if (RdAddrB == AddrBits'(i)) rd_b = words[i];
    end
  end

  assign QA = csA ? {NrOfBits{1'bz}} : rd_a;
  assign QB = csB ? {NrOfBits{1'bz}} : rd_b;

endmodule

// File: tb/tb_register_bank_s10.sv
// Scoreboard bench: a rising-edge 4-word bank and a falling-edge 3-word bank
// share stimulus; an array model predicts reads and wrap pulses for both.
module tb_register_bank_s10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       pre = 1'b0;
  logic       ClockEnable = 1'b0;
  logic       Tick = 1'b0;
  logic [1:0] WrAddr = '0;
  logic [1:0] WrMode = '0;
  logic [7:0] D = '0;
  logic [1:0] RdAddrA = '0;
  logic [1:0] RdAddrB = '0;
  logic       csA = 1'b0;
  logic       csB = 1'b0;
  wire  [7:0] qa1, qb1, qa2, qb2;
  wire        wrap1, wrap2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  register_bank_s10 #(
    .ActiveLevel (1'b1), .NrOfBits (8), .NrOfRegs (4), .AddrBits (2)
  ) dut (
    .Clock (Clock), .Reset (Reset), .pre (pre), .ClockEnable (ClockEnable), .Tick (Tick),
    .WrAddr (WrAddr), .WrMode (WrMode), .D (D), .RdAddrA (RdAddrA), .RdAddrB (RdAddrB),
    .csA (csA), .csB (csB), .QA (qa1), .QB (qb1), .Wrap (wrap1)
  );

  register_bank_s10 #(
    .ActiveLevel (1'b0), .NrOfBits (8), .NrOfRegs (3), .AddrBits (2)
  ) dut_fall (
    .Clock (Clock), .Reset (Reset), .pre (pre), .ClockEnable (ClockEnable), .Tick (Tick),
    .WrAddr (WrAddr), .WrMode (WrMode), .D (D), .RdAddrA (RdAddrA), .RdAddrB (RdAddrB),
    .csA (csA), .csB (csB), .QA (qa2), .QB (qb2), .Wrap (wrap2)
  );

  typedef struct packed {
    logic [7:0] qa1;
    logic [7:0] qb1;
    logic       w1;
    logic [7:0] qa2;
    logic [7:0] qb2;
    logic       w2;
  } exp_t;

  exp_t exp_pre_q[$];   // sampled before the falling edge
  exp_t exp_post_q[$];  // sampled just after the falling edge

  // Reference model: word contents and last wrap result for each bank.
  logic [7:0] m [2][4];
  logic       mw [2];
  int         nregs [2] = '{4, 3};

  function automatic logic [7:0] rd(int inst, logic [1:0] a, logic cs);
    if (cs) return 8'bz;
    if (int'(a) >= nregs[inst]) return 8'h00;
    return m[inst][a];
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit pr, bit ce, bit tk, logic [1:0] wa, logic [1:0] md,
                       logic [7:0] dd, logic [1:0] ra, logic [1:0] rb, bit ca, bit cb);
    exp_t ea, eb;
    int   v;
    @(posedge Clock);
    #1;
    Reset = rst; pre = pr; ClockEnable = ce; Tick = tk; WrAddr = wa; WrMode = md;
    D = dd; RdAddrA = ra; RdAddrB = rb; csA = ca; csB = cb;
    if (rst || pr) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) m[k][i] = rst ? 8'h00 : 8'hFF;
        mw[k] = 1'b0;
      end
    end
    ea = '{rd(0, ra, ca), rd(0, rb, cb), mw[0], rd(1, ra, ca), rd(1, rb, cb), mw[1]};
    if (!rst && !pr) begin
      for (int k = 0; k < 2; k++) begin
        mw[k] = 1'b0;
        if (ce && tk && int'(wa) < nregs[k]) begin
          v = int'(m[k][wa]);
          case (md)
            2'd1: v = int'(dd);
            2'd2: begin mw[k] = (v == 255); v = (v + 1) % 256; end
            2'd3: begin mw[k] = (v == 0);   v = (v + 255) % 256; end
            default: ;
          endcase
          m[k][wa] = 8'(v);
        end
      end
    end
    // Rising-edge bank has not updated yet; falling-edge bank has.
    eb = '{ea.qa1, ea.qb1, ea.w1, rd(1, ra, ca), rd(1, rb, cb), mw[1]};
    exp_pre_q.push_back(ea);
    exp_post_q.push_back(eb);
  endtask

  // Monitor: compares DUT outputs against queued predictions twice per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #3;
      if (exp_pre_q.size() != 0) begin
        e = exp_pre_q.pop_front();
        chk("pre.QA_rise", qa1, e.qa1);   chk("pre.QB_rise", qb1, e.qb1);
        chk("pre.Wrap_rise", {7'd0, wrap1}, {7'd0, e.w1});
        chk("pre.QA_fall", qa2, e.qa2);   chk("pre.QB_fall", qb2, e.qb2);
        chk("pre.Wrap_fall", {7'd0, wrap2}, {7'd0, e.w2});
      end
      @(negedge Clock);
      #1;
      if (exp_post_q.size() != 0) begin
        e = exp_post_q.pop_front();
        chk("post.QA_rise", qa1, e.qa1);  chk("post.QB_rise", qb1, e.qb1);
        chk("post.Wrap_rise", {7'd0, wrap1}, {7'd0, e.w1});
        chk("post.QA_fall", qa2, e.qa2);  chk("post.QB_fall", qb2, e.qb2);
        chk("post.Wrap_fall", {7'd0, wrap2}, {7'd0, e.w2});
      end
    end
  end

  initial begin
    logic [7:0] rd_data;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = 8'h00;
      mw[k] = 1'b0;
    end
    // Reset, preset, and both together
    drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 2, 3, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 8'h00, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 1, 2, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 8'h00, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 1, 3, 0, 0);
    // Load 5A into word 2, then a load with Tick low
    drive(0, 0, 1, 1, 2, 2'd1, 8'h5A, 2, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 2'd0, 8'h00, 2, 2, 0, 0);
    drive(0, 0, 1, 0, 2, 2'd1, 8'h33, 2, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 2'd0, 8'h00, 2, 2, 0, 0);
    // FE -> FF -> 00 with wrap, then 00 -> FF with wrap
    drive(0, 0, 1, 1, 1, 2'd1, 8'hFE, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 2'd2, 8'h00, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 2'd2, 8'h00, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 2'd0, 8'h00, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 2'd3, 8'h00, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 2'd0, 8'h00, 1, 1, 0, 0);
    // Port A released, port B watching the word being loaded (word 3 too)
    drive(0, 0, 1, 1, 3, 2'd1, 8'hC3, 0, 3, 1, 0);
    drive(0, 0, 1, 1, 2, 2'd1, 8'h77, 3, 2, 0, 0);
    drive(0, 0, 1, 1, 2, 2'd0, 8'h00, 3, 2, 0, 1);
    // Reset between two increments
    drive(0, 0, 1, 1, 0, 2'd1, 8'h10, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 2'd2, 8'h00, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 2'd2, 8'h00, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 2'd2, 8'h00, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0, 0);
    // Random traffic, data biased toward wrap boundaries
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(3))
        0: rd_data = 8'hFF;
        1: rd_data = 8'h00;
        default: rd_data = 8'($urandom);
      endcase
      drive($urandom_range(39) == 0, $urandom_range(39) == 0,
            $urandom_range(3) != 0, $urandom_range(3) != 0,
            2'($urandom), 2'($urandom), rd_data, 2'($urandom), 2'($urandom),
            $urandom_range(4) == 0, $urandom_range(4) == 0);
    end
    repeat (3) @(posedge Clock);
    n_checks++;
    if (exp_pre_q.size() != 0 || exp_post_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d left, expected 0/0",
               exp_pre_q.size(), exp_post_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
